// File: rtl/delay_sweep_fsm.sv
// Per-lane delay-line training sequencer: sweeps taps upward, finds the passing window, walks back to its centre.
// Define DELAY_SWEEP_TIMEOUT_EN to add a watchdog on the sample handshake.
module delay_sweep_fsm #(
  parameter int WIDTH       = 7,
  parameter int RESET_VAL   = 1,
  parameter int MAX_TAP     = 126,
  parameter int SETTLE_CYC  = 4,
  parameter int MIN_WIN     = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             sclk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             sample_pass,
  input  logic             out_of_range,
  input  logic [WIDTH-1:0] delay_val,
  output logic             sample_req,
  output logic             dly_enable,
  output logic             dly_load,
  output logic             dly_move,
  output logic             dly_direction,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] left_edge,
  output logic [WIDTH-1:0] right_edge,
  output logic [WIDTH-1:0] centre
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD    = 4'd1;
  localparam logic [3:0] S_MOVE_HI = 4'd2;
  localparam logic [3:0] S_MOVE_LO = 4'd3;
  localparam logic [3:0] S_SETTLE  = 4'd4;
  localparam logic [3:0] S_SAMPLE  = 4'd5;
  localparam logic [3:0] S_EVAL    = 4'd6;
  localparam logic [3:0] S_CENTRE  = 4'd7;
  localparam logic [3:0] S_CCHK    = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_FAIL    = 4'd10;

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int RUN_W = $clog2(MIN_WIN + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(MIN_WIN);
  localparam logic [WIDTH-1:0] TAP_LAST = WIDTH'(MAX_TAP);

  // The downstream register freezes at all-ones, so the sweep must stop short of it.
  if (RESET_VAL < 1 || MAX_TAP >= (2**WIDTH) - 1 || SETTLE_CYC < 1 || MIN_WIN < 1 ||
      TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("delay_sweep_fsm: illegal parameter set");
  end

  function automatic logic [WIDTH-1:0] mid_tap(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH:1];
  endfunction

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] r);
    return (r >= RUN_FULL) ? RUN_FULL : r + RUN_W'(1);
  endfunction

  logic [3:0]       state, state_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic [WIDTH-1:0] cand_left, cand_nxt;
  logic             pass_q;
  logic             cen_phase;
  logic             at_end, fail_close, end_close, tmo_hit;

`ifdef DELAY_SWEEP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)               tmo_cnt <= '0;
    else if (state == S_SAMPLE) tmo_cnt <= tmo_cnt + TMO_W'(1);
    else                        tmo_cnt <= '0;
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // Window bookkeeping for the tap just sampled.
  always_comb begin
    run_nxt    = pass_q ? run_sat_inc(run_cnt) : '0;
    cand_nxt   = (pass_q && run_cnt == '0) ? delay_val : cand_left;
    at_end     = (delay_val == TAP_LAST) || out_of_range;
    fail_close = !pass_q && (run_cnt >= RUN_FULL);
    end_close  = at_end && (run_nxt >= RUN_FULL);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_SETTLE;
      S_MOVE_HI: state_nxt = S_MOVE_LO;
      S_MOVE_LO: state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SET_LAST) state_nxt = cen_phase ? S_CCHK : S_SAMPLE;
      S_SAMPLE: begin
        if (sample_valid) state_nxt = S_EVAL;
        else if (tmo_hit) state_nxt = S_FAIL;
      end
      S_EVAL: begin
        if (fail_close || end_close) state_nxt = S_CENTRE;
        else if (at_end)             state_nxt = S_FAIL;
        else                         state_nxt = S_MOVE_HI;
      end
      S_CENTRE:  state_nxt = S_CCHK;
      S_CCHK: begin
        if (delay_val == centre)     state_nxt = S_DONE;
        else if (delay_val < centre) state_nxt = S_FAIL;
        else                         state_nxt = S_MOVE_HI;
      end
      S_DONE:    state_nxt = S_IDLE;
      S_FAIL:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so dly_move/dly_load never glitch.
  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      dly_enable <= 1'b0;
      busy       <= 1'b0;
      dly_load   <= 1'b0;
      dly_move   <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      state      <= state_nxt;
      dly_enable <= !(state_nxt inside {S_IDLE, S_DONE, S_FAIL});
      busy       <= !(state_nxt inside {S_IDLE, S_DONE, S_FAIL});
      dly_load   <= (state_nxt == S_LOAD);
      dly_move   <= (state_nxt == S_MOVE_HI);
      sample_req <= (state_nxt == S_SAMPLE);
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n)               settle_cnt <= '0;
    else if (state == S_SETTLE) settle_cnt <= settle_cnt + SET_W'(1);
    else                        settle_cnt <= '0;
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      dly_direction <= 1'b1;
      done          <= 1'b0;
      fail          <= 1'b0;
      left_edge     <= '0;
      right_edge    <= '0;
      centre        <= '0;
      run_cnt       <= '0;
      cand_left     <= '0;
      pass_q        <= 1'b0;
      cen_phase     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          done          <= 1'b0;
          fail          <= 1'b0;
          left_edge     <= '0;
          right_edge    <= '0;
          centre        <= '0;
          run_cnt       <= '0;
          cand_left     <= '0;
          cen_phase     <= 1'b0;
          dly_direction <= 1'b1;
        end
        S_SAMPLE: if (sample_valid) pass_q <= sample_pass;
        S_EVAL: begin
          run_cnt   <= run_nxt;
          cand_left <= cand_nxt;
          if (fail_close) begin
            left_edge  <= cand_left;
            right_edge <= delay_val - WIDTH'(1);
            cen_phase  <= 1'b1;
          end else if (end_close) begin
            left_edge  <= cand_nxt;
            right_edge <= delay_val;
            cen_phase  <= 1'b1;
          end else if (!at_end) begin
            dly_direction <= 1'b1;
          end
        end
        S_CENTRE: centre <= mid_tap(left_edge, right_edge);
        // Walk-back always steps down: the sweep stops at or just above right_edge.
        S_CCHK: if (delay_val > centre) dly_direction <= 1'b0;
        default: ;
      endcase
      if (state_nxt == S_DONE) done <= 1'b1;
      if (state_nxt == S_FAIL) begin
        fail       <= 1'b1;
        left_edge  <= '0;
        right_edge <= '0;
        centre     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_delay_sweep_fsm.sv
// Directed bench for delay_sweep_fsm with a behavioural model of the downstream delay register.
module tb_delay_sweep_fsm;

  logic       sclk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       sample_valid;
  logic       sample_pass;
  logic       out_of_range;
  logic [6:0] delay_val;
  logic       sample_req, dly_enable, dly_load, dly_move, dly_direction;
  logic       busy, done, fail;
  logic [6:0] left_edge, right_edge, centre;

  int checks = 0;
  int errors = 0;
  int tap = 0;
  int max_tap = 0;
  bit move_q = 1'b0;
  bit respond = 1'b1;
  int lo1, hi1, lo2, hi2;
  bit fin;
  int cyc;

  delay_sweep_fsm dut (
    .sclk(sclk), .reset_n(reset_n), .start(start),
    .sample_valid(sample_valid), .sample_pass(sample_pass),
    .out_of_range(out_of_range), .delay_val(delay_val),
    .sample_req(sample_req), .dly_enable(dly_enable), .dly_load(dly_load),
    .dly_move(dly_move), .dly_direction(dly_direction),
    .busy(busy), .done(done), .fail(fail),
    .left_edge(left_edge), .right_edge(right_edge), .centre(centre)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit pass_fn(input int t);
    return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
  endfunction

  // Called at each falling edge: mirrors what the downstream register does on the next rising edge.
  task automatic model_step();
    if (dly_enable && dly_load) tap = 1;
    else if (dly_enable && dly_move && !move_q) begin
      if (dly_direction) begin if (tap < 127) tap++; end
      else begin if (tap > 0) tap--; end
    end
    move_q = dly_move;
    if (tap > max_tap) max_tap = tap;
    delay_val    = 7'(tap);
    out_of_range = (tap == 127);
    sample_valid = respond && sample_req;
    sample_pass  = pass_fn(tap);
  endtask

  task automatic run_train(input int budget, input bit extra, output bit f, output int n);
    @(negedge sclk);
    model_step();
    start   = 1'b1;
    max_tap = 0;
    n = 0;
    f = 1'b0;
    while (!f && n < budget) begin
      @(negedge sclk);
      start = extra && (n % 17 == 5);
      model_step();
      n++;
      if (done || fail) f = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample_pass = 1'b0;
    out_of_range = 1'b0; delay_val = '0;
    lo1 = 200; hi1 = 0; lo2 = 200; hi2 = 0;
    repeat (3) @(negedge sclk);
    chk("rst_req", sample_req, 0);
    chk("rst_en", dly_enable, 0);
    chk("rst_load", dly_load, 0);
    chk("rst_move", dly_move, 0);
    chk("rst_dir", dly_direction, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_left", left_edge, 0);
    chk("rst_right", right_edge, 0);
    chk("rst_centre", centre, 0);
    reset_n = 1'b1;

    // Window 10..40, closed by a failing tap.
    lo1 = 10; hi1 = 40;
    run_train(3000, 1'b0, fin, cyc);
    chk("t1_fin", fin, 1);
    chk("t1_cycles", cyc, 442);
    chk("t1_left", left_edge, 10);
    chk("t1_right", right_edge, 40);
    chk("t1_centre", centre, 25);
    chk("t1_done", done, 1);
    chk("t1_fail", fail, 0);
    chk("t1_tap", delay_val, 25);
    chk("t1_en", dly_enable, 0);
    chk("t1_busy", busy, 0);
    chk("t1_dir", dly_direction, 0);

    // Short run 5..6 discarded; 20..22 is the window.
    lo1 = 5; hi1 = 6; lo2 = 20; hi2 = 22;
    run_train(3000, 1'b0, fin, cyc);
    chk("t2_fin", fin, 1);
    chk("t2_left", left_edge, 20);
    chk("t2_right", right_edge, 22);
    chk("t2_centre", centre, 21);
    chk("t2_done", done, 1);
    chk("t2_tap", delay_val, 21);

    // Window runs into the last tap.
    lo1 = 120; hi1 = 127; lo2 = 200; hi2 = 0;
    run_train(3000, 1'b0, fin, cyc);
    chk("t3_fin", fin, 1);
    chk("t3_left", left_edge, 120);
    chk("t3_right", right_edge, 126);
    chk("t3_centre", centre, 123);
    chk("t3_done", done, 1);
    chk("t3_tap", delay_val, 123);
    chk("t3_maxtap", max_tap, 126);

    // No passing tap at all.
    lo1 = 200; hi1 = 0;
    run_train(3000, 1'b0, fin, cyc);
    chk("t4_fin", fin, 1);
    chk("t4_fail", fail, 1);
    chk("t4_done", done, 0);
    chk("t4_left", left_edge, 0);
    chk("t4_right", right_edge, 0);
    chk("t4_centre", centre, 0);
    chk("t4_busy", busy, 0);
    chk("t4_maxtap", max_tap, 126);

    // Reset in the middle of SETTLE, then a clean run with stray start pulses.
    lo1 = 10; hi1 = 40;
    @(negedge sclk); start = 1'b1;
    @(negedge sclk); start = 1'b0;
    @(negedge sclk);
    @(negedge sclk);
    chk("t5_busy_pre", busy, 1);
    chk("t5_en_pre", dly_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_en", dly_enable, 0);
    chk("t5_busy", busy, 0);
    chk("t5_load", dly_load, 0);
    chk("t5_move", dly_move, 0);
    chk("t5_req", sample_req, 0);
    chk("t5_dir", dly_direction, 1);
    chk("t5_fail", fail, 0);
    @(negedge sclk); reset_n = 1'b1;
    run_train(3000, 1'b1, fin, cyc);
    chk("t5_fin", fin, 1);
    chk("t5_cycles", cyc, 442);
    chk("t5_centre", centre, 25);
    chk("t5_done", done, 1);

    // Sample handshake never answered.
    respond = 1'b0;
    run_train(300, 1'b0, fin, cyc);
`ifdef DELAY_SWEEP_TIMEOUT_EN
    chk("t6_fin", fin, 1);
    chk("t6_cycles", cyc, 261);
    chk("t6_fail", fail, 1);
    chk("t6_req", sample_req, 0);
    chk("t6_busy", busy, 0);
`else
    chk("t6_fin", fin, 0);
    chk("t6_busy", busy, 1);
    chk("t6_req", sample_req, 1);
    chk("t6_fail", fail, 0);
`endif
    reset_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 0);
    respond = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
